// File: rtl/rv_fetch_pf_pkg.sv
// Shared types and constants for the prefetching fetch unit and its FIFO.
// A fetch entry is the word returned by memory together with the PC it was read from.
package rv_fetch_pf_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rv_fetch_pf_if.sv
// Instruction-memory read bus: pipelined requests, in-order response strobes.
interface rv_fetch_pf_if;
  import rv_fetch_pf_pkg::*;

  logic [XLEN-1:0] im_addr_o;
  logic            im_rd_o;
  logic [XLEN-1:0] im_data_i;
  logic            im_valid_i;

  modport master (
    output im_addr_o,
    output im_rd_o,
    input  im_data_i,
    input  im_valid_i
  );

  modport slave (
    input  im_addr_o,
    input  im_rd_o,
    output im_data_i,
    output im_valid_i
  );

endinterface

// File: rtl/rv_fetch_fifo.sv
// Synchronous FIFO with flush, same-cycle push/pop and a combinational head.
// The owner guarantees no push into a full FIFO unless it pops in the same cycle.
module rv_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged, even when full.
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/rv_fetch_pf.sv
// Prefetching instruction fetch: credit-limited pipelined reads, PC-tagged FIFO to decode,
// and branch redirect that flushes the FIFO and drops stale in-flight responses.
module rv_fetch_pf
  import rv_fetch_pf_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rv_fetch_pf_if.master       im,
  input  logic                f_stall_i,
  input  logic                f_kill_i,
  output logic [XLEN-1:0]     f_ir_o,
  output logic [XLEN-1:0]     f_pc_o,
  output logic [XLEN-1:0]     f_pc_plus_4_o,
  output logic                f_valid_o,
  input  logic [XLEN-1:0]     x_pc_bra_i,
  input  logic                x_bra_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outs_q, outs_d;
  logic [CW-1:0]   disc_q, disc_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  logic [CW:0]     credit_used;
  logic            issue;
  logic            resp;
  logic            push;
  logic            pop;

  always_comb begin
    credit_used = {1'b0, fifo_count} + {1'b0, outs_q};
    // Counting in-flight reads against FIFO space guarantees every response has a slot.
    issue = !rst_i && !x_bra_i && (credit_used < (CW+1)'(FIFO_DEPTH));
    resp  = im.im_valid_i && (outs_q != '0);
    push  = resp && (disc_q == '0) && !x_bra_i;
    pop   = !fifo_empty && (!f_stall_i || f_kill_i) && !x_bra_i;

    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outs_d    = outs_q;
    disc_d    = disc_q;

    if (x_bra_i) begin
      pc_d      = word_align(x_pc_bra_i);
      resp_pc_d = word_align(x_pc_bra_i);
      outs_d    = outs_q - CW'(resp);
      // Every read still in flight is wrong-path, including any already marked for discard.
      disc_d    = outs_q - CW'(resp);
    end else begin
      if (issue) begin
        pc_d = pc_q + 32'd4;
      end
      outs_d = outs_q + CW'(issue) - CW'(resp);
      if (resp) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= RESET_VECTOR;
      resp_pc_q <= RESET_VECTOR;
      outs_q    <= '0;
      disc_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outs_q    <= outs_d;
      disc_q    <= disc_d;
    end
  end

  assign push_entry = '{pc: resp_pc_q, ir: im.im_data_i};

  rv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (x_bra_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign im.im_rd_o    = issue;
  assign im.im_addr_o  = pc_q;

  assign f_valid_o     = !fifo_empty && !f_kill_i;
  assign f_ir_o        = head.ir;
  assign f_pc_o        = head.pc;
  assign f_pc_plus_4_o = head.pc + 32'd4;

endmodule

// File: tb/tb_rv_fetch_pf.sv
// Self-checking bench for rv_fetch_pf: latency-programmable memory model, fetch-stream
// scoreboard, a per-cycle timing table after reset and hand sequences for corner cases.
module tb_rv_fetch_pf;

  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        f_stall_i = 1'b0;
  logic        f_kill_i = 1'b0;
  logic        x_bra_i = 1'b0;
  logic [31:0] x_pc_bra_i = 32'h0;
  logic [31:0] f_ir_o, f_pc_o, f_pc_plus_4_o;
  logic        f_valid_o;

  rv_fetch_pf_if im_bus ();

  rv_fetch_pf #(
    .RESET_VECTOR (RV),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .im            (im_bus),
    .f_stall_i     (f_stall_i),
    .f_kill_i      (f_kill_i),
    .f_ir_o        (f_ir_o),
    .f_pc_o        (f_pc_o),
    .f_pc_plus_4_o (f_pc_plus_4_o),
    .f_valid_o     (f_valid_o),
    .x_pc_bra_i    (x_pc_bra_i),
    .x_bra_i       (x_bra_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;
  typedef struct {
    logic        stall;
    logic        exp_rd;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          lat = 1;
  int          checks = 0;
  int          errs = 0;
  int          req_cnt = 0;
  logic [31:0] exp_fetch_pc = RV;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, want, cyc);
    end else begin
      $display("ok   %s: %08h (cycle %0d)", name, got, cyc);
    end
  endtask

  task automatic chk_b(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, want, cyc);
    end else begin
      $display("ok   %s: %b (cycle %0d)", name, got, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!f_valid_o && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!f_valid_o) begin
      checks++;
      errs++;
      $display("FAIL %s: f_valid_o never rose within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic do_reset(input int hold, input bit keep_mem);
    rst_i     = 1'b1;
    f_stall_i = 1'b0;
    f_kill_i  = 1'b0;
    x_bra_i   = 1'b0;
    if (!keep_mem) mem_q.delete();
    exp_q.delete();
    exp_fetch_pc = RV;
    repeat (hold) @(posedge clk);
    #1;
    chk_b("rst_im_rd", im_bus.im_rd_o, 1'b0);
    chk_b("rst_f_valid", f_valid_o, 1'b0);
    chk("rst_f_ir", f_ir_o, 32'h0);
    chk("rst_f_pc", f_pc_o, 32'h0);
    chk("rst_f_pc_plus_4", f_pc_plus_4_o, 32'h4);
    rst_i = 1'b0;
  endtask

  // Memory: answers each request exactly lat cycles after it was issued, in order.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      im_bus.im_valid_i = 1'b1;
      im_bus.im_data_i  = memf(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      im_bus.im_valid_i = 1'b0;
      im_bus.im_data_i  = 32'h0;
    end
  end

  // Scoreboard: requests push the expected stream, decode consumption pops it.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (x_bra_i) begin
        chk_b("no_issue_in_branch", im_bus.im_rd_o, 1'b0);
        exp_q.delete();
        exp_fetch_pc = {x_pc_bra_i[31:2], 2'b00};
      end else if (f_kill_i) begin
        chk_b("kill_hides_valid", f_valid_o, 1'b0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (f_valid_o && !f_stall_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_instr: got pc %08h expected none", f_pc_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_pc", f_pc_o, mon_e.pc);
          chk("sb_ir", f_ir_o, mon_e.ir);
          chk("sb_pc_plus_4", f_pc_plus_4_o, mon_e.pc + 32'd4);
        end
      end
      if (im_bus.im_rd_o) begin
        chk("fetch_addr", im_bus.im_addr_o, exp_fetch_pc);
        mem_q.push_back('{im_bus.im_addr_o, cyc + lat});
        exp_q.push_back('{exp_fetch_pc, memf(exp_fetch_pc)});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        req_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl[7];

  initial begin
    im_bus.im_valid_i = 1'b0;
    im_bus.im_data_i  = 32'h0;

    // Cycle-by-cycle timing after reset, latency 1, depth 2, no stall.
    tbl[0] = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100};
    tbl[3] = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h104};
    tbl[4] = '{1'b0, 1'b1, 32'h10C, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108};
    tbl[6] = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h10C};

    lat = 1;
    do_reset(3, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      f_stall_i = tbl[i].stall;
      @(negedge clk);
      chk_b("tbl_im_rd", im_bus.im_rd_o, tbl[i].exp_rd);
      if (tbl[i].exp_rd) chk("tbl_im_addr", im_bus.im_addr_o, tbl[i].exp_addr);
      chk_b("tbl_f_valid", f_valid_o, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk("tbl_f_pc", f_pc_o, tbl[i].exp_pc);
    end

    // Stall held: credits run out after two requests, head stays put.
    tick();
    do_reset(3, 1'b0);
    f_stall_i = 1'b1;
    req_cnt = 0;
    repeat (7) tick();
    @(negedge clk);
    chk("stall_req_count", 32'(req_cnt), 32'd2);
    chk_b("stall_no_rd", im_bus.im_rd_o, 1'b0);
    chk_b("stall_head_valid", f_valid_o, 1'b1);
    chk("stall_head_pc", f_pc_o, 32'h100);
    tick();
    f_stall_i = 1'b0;
    @(negedge clk);
    chk("release_pc0", f_pc_o, 32'h100);
    tick();
    @(negedge clk);
    chk_b("release_valid1", f_valid_o, 1'b1);
    chk("release_pc1", f_pc_o, 32'h104);

    // Branch with two reads in flight at latency 3.
    tick();
    lat = 3;
    do_reset(3, 1'b0);
    tick();
    tick();
    x_bra_i = 1'b1;
    x_pc_bra_i = 32'h203;
    tick();
    x_bra_i = 1'b0;
    wait_valid("bra_inflight_wait", 30);
    chk("bra_inflight_pc", f_pc_o, 32'h200);
    chk("bra_inflight_ir", f_ir_o, memf(32'h200));

    // Branch coinciding with a response and a stalled head.
    tick();
    lat = 1;
    do_reset(3, 1'b0);
    f_stall_i = 1'b1;
    tick();
    tick();
    x_bra_i = 1'b1;
    x_pc_bra_i = 32'h300;
    @(negedge clk);
    chk_b("bra_resp_present", im_bus.im_valid_i, 1'b1);
    chk_b("bra_old_head_valid", f_valid_o, 1'b1);
    chk("bra_old_head_pc", f_pc_o, 32'h100);
    tick();
    x_bra_i = 1'b0;
    f_stall_i = 1'b0;
    @(negedge clk);
    chk_b("bra_flushed", f_valid_o, 1'b0);
    wait_valid("bra_resp_wait", 10);
    chk("bra_resp_pc0", f_pc_o, 32'h300);
    tick();
    @(negedge clk);
    chk("bra_resp_pc1", f_pc_o, 32'h304);

    // Kill while stalled pops the head.
    tick();
    do_reset(3, 1'b0);
    f_stall_i = 1'b1;
    repeat (3) tick();
    f_kill_i = 1'b1;
    @(negedge clk);
    chk_b("kill_valid_low", f_valid_o, 1'b0);
    tick();
    f_kill_i = 1'b0;
    @(negedge clk);
    chk_b("kill_next_valid", f_valid_o, 1'b1);
    chk("kill_next_pc", f_pc_o, 32'h104);
    tick();
    f_stall_i = 1'b0;
    repeat (3) tick();

    // Branch to the top of the address space; fetch wraps to 0.
    x_bra_i = 1'b1;
    x_pc_bra_i = 32'hFFFF_FFFC;
    tick();
    x_bra_i = 1'b0;
    wait_valid("wrap_wait0", 10);
    chk("wrap_pc", f_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc_plus_4", f_pc_plus_4_o, 32'h0);
    tick();
    wait_valid("wrap_wait1", 10);
    chk("wrap_next_pc", f_pc_o, 32'h0);

    // Reset mid-stream: stale responses that land after reset must be ignored.
    tick();
    lat = 3;
    repeat (6) tick();
    do_reset(2, 1'b1);
    wait_valid("mid_rst_wait", 20);
    chk("mid_rst_pc", f_pc_o, RV);
    tick();
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
